// File: rtl/pwm_out_ctrl_if.sv
// pwm_out_ctrl_if: register write channel into the PWM output controller
// Ports: wr_valid/wr_addr/wr_data driven by the master, wr_ready returned by the controller
interface pwm_out_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/pwm_out_ctrl.sv
// pwm_out_ctrl: shadowed duty/mode registers and shared PWM period counter for the 7-bit output stage
// Ports: clk, rst_n (async active-low); wr (write channel, slave side);
//        pwm_dc per-channel PWM level; sel_pwm, invert_polarity, ovalues from the active set;
//        period_tick pulse per boundary while enabled; pending when shadow differs from what was applied
module pwm_out_ctrl #(
    parameter int NCH        = 7,
    parameter int CNT_W      = 7,
    parameter int PERIOD_RST = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_out_ctrl_if.slave    wr,
    output logic [NCH-1:0]   pwm_dc,
    output logic             sel_pwm,
    output logic             invert_polarity,
    output logic [NCH-1:0]   ovalues,
    output logic             period_tick,
    output logic             pending
);
    logic [CNT_W-1:0] duty_sh  [NCH];
    logic [CNT_W-1:0] duty_act [NCH];
    logic [NCH-1:0]   ov_sh, ov_act;
    logic [2:0]       ctrl_sh, ctrl_act;
    logic [CNT_W-1:0] per_sh, per_act, cnt;
    logic             en_act, boundary, apply, acc;
    assign en_act          = ctrl_act[2];
    assign boundary        = en_act && (cnt == per_act);
    // while disabled the shadow is mirrored every edge; while enabled only at the wrap
    assign apply           = !en_act || boundary;
    // writes are refused on the wrap edge so a write can never race the shadow copy
    assign wr.wr_ready     = !boundary;
    assign acc             = wr.wr_valid && wr.wr_ready;
    assign sel_pwm         = ctrl_act[0];
    assign invert_polarity = ctrl_act[1];
    assign ovalues         = ov_act;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
            ov_sh       <= '0;
            ov_act      <= '0;
            ctrl_sh     <= '0;
            ctrl_act    <= '0;
            per_sh      <= CNT_W'(PERIOD_RST);
            per_act     <= CNT_W'(PERIOD_RST);
            cnt         <= '0;
            pwm_dc      <= '0;
            period_tick <= 1'b0;
            pending     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_dc[i] <= en_act && (cnt < duty_act[i]);
                if (apply) duty_act[i] <= duty_sh[i];
                if (acc && wr.wr_addr == 4'(i)) duty_sh[i] <= wr.wr_data[CNT_W-1:0];
            end
            if (apply) begin
                ov_act   <= ov_sh;
                ctrl_act <= ctrl_sh;
                per_act  <= per_sh;
            end
            if (acc && wr.wr_addr == 4'd8) ov_sh <= wr.wr_data[NCH-1:0];
            if (acc && wr.wr_addr == 4'd9) ctrl_sh <= wr.wr_data[2:0];
            if (acc && wr.wr_addr == 4'd10) per_sh <= wr.wr_data[CNT_W-1:0];
            cnt         <= apply ? '0 : cnt + 1'b1;
            period_tick <= boundary;
            pending     <= acc ? 1'b1 : apply ? 1'b0 : pending;
        end
    end
endmodule

// File: tb/tb_pwm_out_ctrl.sv
// tb_pwm_out_ctrl: scoreboard bench with a behavioural reference model for pwm_out_ctrl
module tb_pwm_out_ctrl;
    logic clk = 0, rst_n = 0;
    logic [6:0] pwm_dc, ovalues;
    logic sel_pwm, invert_polarity, period_tick, pending;
    int checks = 0, fails = 0;
    pwm_out_ctrl_if bus();
    pwm_out_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr(bus), .pwm_dc(pwm_dc), .sel_pwm(sel_pwm),
        .invert_polarity(invert_polarity), .ovalues(ovalues),
        .period_tick(period_tick), .pending(pending)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [6:0] dc;
        logic       sel, inv;
        logic [6:0] ov;
        logic       tick, pend, rdy;
    } obs_t;
    obs_t q[$];
    // reference model: a register file of shadow/active settings and a position within the period
    int m_duty_sh[7], m_duty[7];
    int m_ov_sh, m_ov, m_ctrl_sh, m_ctrl, m_per_sh, m_per, m_pos;
    bit m_pend, m_en, m_wrap, m_acc;
    obs_t e;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_duty[c]) begin m_duty_sh[c] = 0; m_duty[c] = 0; end
            m_ov_sh = 0; m_ov = 0; m_ctrl_sh = 0; m_ctrl = 0;
            m_per_sh = 127; m_per = 127; m_pos = 0; m_pend = 0;
            q.delete();
        end else begin
            m_en   = m_ctrl[2];
            m_wrap = m_en && m_pos == m_per;
            m_acc  = bus.wr_valid && !m_wrap;
            for (int c = 0; c < 7; c++) e.dc[c] = m_en && m_pos < m_duty[c];
            e.tick = m_wrap;
            if (m_acc) m_pend = 1; else if (!m_en || m_wrap) m_pend = 0;
            m_pos = (m_en && !m_wrap) ? m_pos + 1 : 0;
            if (!m_en || m_wrap) begin
                m_duty = m_duty_sh; m_ov = m_ov_sh; m_ctrl = m_ctrl_sh; m_per = m_per_sh;
            end
            if (m_acc) begin
                if (bus.wr_addr < 7) m_duty_sh[bus.wr_addr] = bus.wr_data % 128;
                else if (bus.wr_addr == 8) m_ov_sh = bus.wr_data % 128;
                else if (bus.wr_addr == 9) m_ctrl_sh = bus.wr_data % 8;
                else if (bus.wr_addr == 10) m_per_sh = bus.wr_data % 128;
            end
            e.sel = m_ctrl[0]; e.inv = m_ctrl[1]; e.ov = 7'(m_ov); e.pend = m_pend;
            e.rdy = !(m_ctrl[2] && m_pos == m_per);
            q.push_back(e);
        end
    end
    obs_t a, x;
    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            x = q.pop_front();
            a = '{pwm_dc, sel_pwm, invert_polarity, ovalues, period_tick, pending, bus.wr_ready};
            checks++;
            if (a !== x) begin
                fails++;
                $display("FAIL cycle_obs t=%0t got dc=%h sel=%b inv=%b ov=%h tick=%b pend=%b rdy=%b want dc=%h sel=%b inv=%b ov=%h tick=%b pend=%b rdy=%b",
                         $time, a.dc, a.sel, a.inv, a.ov, a.tick, a.pend, a.rdy,
                         x.dc, x.sel, x.inv, x.ov, x.tick, x.pend, x.rdy);
            end
        end
    end
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    // called at a negedge; returns at the negedge after the accepting posedge
    task automatic wr(input logic [3:0] ad, input logic [7:0] d);
        int n = 0;
        bus.wr_valid = 1; bus.wr_addr = ad; bus.wr_data = d;
        while (!bus.wr_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            checks++; fails++;
            $display("FAIL wr_timeout addr=%0d got=not_accepted want=accepted", ad);
        end
        @(negedge clk);
        bus.wr_valid = 0;
    endtask
    initial begin
        int n;
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        #12;
        chk("rst_pwm_dc", 8'(pwm_dc), 8'h0);
        chk("rst_wr_ready", 8'(bus.wr_ready), 8'h1);
        @(negedge clk); #1 rst_n = 1;
        @(negedge clk);
        wr(10, 9); wr(0, 3); wr(9, 8'h05);
        idle(30);
        idle(4); wr(0, 7); idle(25);
        n = 0;
        while (bus.wr_ready && n < 50) begin @(negedge clk); n++; end
        chk("wr_ready_low_at_wrap", 8'(bus.wr_ready), 8'h0);
        wr(1, 0); wr(2, 12); idle(25);
        idle(3); wr(9, 8'h06); idle(15); wr(8, 8'h55); idle(25);
        wr(9, 8'h05);
        repeat (60) begin
            logic [3:0] ad;
            logic [7:0] d;
            ad = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            if (ad == 10) d = 8'($urandom_range(2, 15));
            wr(ad, d);
            idle($urandom_range(0, 8));
        end
        wr(10, 9); wr(9, 8'h05); idle(140);
        wr(0, 4);
        #1 chk("pending_before_reset", 8'(pending), 8'h1);
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("arst_pwm_dc", 8'(pwm_dc), 8'h0);
        chk("arst_ctrl", {6'b0, sel_pwm, invert_polarity}, 8'h0);
        chk("arst_ovalues", 8'(ovalues), 8'h0);
        chk("arst_tick", 8'(period_tick), 8'h0);
        chk("arst_pending", 8'(pending), 8'h0);
        chk("arst_wr_ready", 8'(bus.wr_ready), 8'h1);
        @(negedge clk); #1 rst_n = 1;
        idle(3);
        wr(10, 0); wr(2, 12); wr(9, 8'h05);
        idle(6);
        chk("p0_tick", 8'(period_tick), 8'h1);
        chk("p0_dc2", 8'(pwm_dc[2]), 8'h1);
        chk("p0_wr_ready", 8'(bus.wr_ready), 8'h0);
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
